// File: rtl/tt_spine_sel_ctrl.sv
// tt_spine_sel_ctrl: spine select/enable driver at the spine root.
// Syncs pads, holds the pending address, applies it glitch-free.

module tt_spine_sel_ctrl #(
  parameter int N_SEL       = 10,
  parameter int GUARD_CYC   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_sel_rst_n,
  input  logic             pad_sel_inc,
  input  logic             pad_ena,
  input  logic             cfg_load,
  input  logic [N_SEL-1:0] cfg_addr,
  output logic [N_SEL-1:0] spine_sel,
  output logic             spine_ena,
  output logic [N_SEL-1:0] sel_pend,
  output logic             busy
);

  localparam int CW = $clog2(GUARD_CYC) + 1;
  localparam logic [CW-1:0] CNT_RLD = CW'(GUARD_CYC - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ON     = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync_rst;
  logic [SYNC_STAGES-1:0] r_sync_inc;
  logic [SYNC_STAGES-1:0] r_sync_ena;
  logic                   r_inc_d;

  logic                   w_s_rst_n;
  logic                   w_s_inc;
  logic                   w_s_ena;
  logic                   w_inc_edge;

  logic [N_SEL-1:0]       r_sel_pend;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nx;
  logic [N_SEL-1:0]       r_spine_sel;
  logic [N_SEL-1:0]       w_sel_nx;
  logic                   r_spine_ena;
  logic                   w_ena_nx;

  logic                   w_mismatch;
  logic                   w_cnt_zero;
  logic [CW-1:0]          w_cnt_dec;
  logic                   w_busy;

  assign w_s_rst_n  = r_sync_rst[SYNC_STAGES-1];
  assign w_s_inc    = r_sync_inc[SYNC_STAGES-1];
  assign w_s_ena    = r_sync_ena[SYNC_STAGES-1];
  assign w_inc_edge = w_s_inc & ~r_inc_d;

  // Pad synchronizer chains plus the inc edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_rst <= '0;
      r_sync_inc <= '0;
      r_sync_ena <= '0;
      r_inc_d    <= 1'b0;
    end else begin
      r_sync_rst <= {r_sync_rst[SYNC_STAGES-2:0], pad_sel_rst_n};
      r_sync_inc <= {r_sync_inc[SYNC_STAGES-2:0], pad_sel_inc};
      r_sync_ena <= {r_sync_ena[SYNC_STAGES-2:0], pad_ena};
      r_inc_d    <= w_s_inc;
    end
  end

  // Pending address: pad reset beats load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_pend <= '0;
    end else if (!w_s_rst_n) begin
      r_sel_pend <= '0;
    end else if (cfg_load) begin
      r_sel_pend <= cfg_addr;
    end else if (w_inc_edge) begin
      r_sel_pend <= r_sel_pend + 1'b1;
    end
  end

  assign w_mismatch = (r_sel_pend != r_spine_sel);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_dec  = r_cnt - 1'b1;

  // State register with the registered spine outputs and guard counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OFF;
      r_cnt       <= '0;
      r_spine_sel <= '0;
      r_spine_ena <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_spine_sel <= w_sel_nx;
      r_spine_ena <= w_ena_nx;
    end
  end

  // Next state: enable drops before select moves, then settles.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sel_nx   = r_spine_sel;
    w_ena_nx   = r_spine_ena;
    unique case (r_state)
      ST_OFF: begin
        w_ena_nx = 1'b0;
        if (w_mismatch) begin
          w_sel_nx   = r_sel_pend;
          w_cnt_nx   = CNT_RLD;
          w_state_nx = ST_SETTLE;
        end else if (w_s_ena) begin
          w_ena_nx   = 1'b1;
          w_state_nx = ST_ON;
        end
      end
      ST_ON: begin
        if (w_mismatch) begin
          w_ena_nx   = 1'b0;
          w_cnt_nx   = CNT_RLD;
          w_state_nx = ST_DRAIN;
        end else if (!w_s_ena) begin
          w_ena_nx   = 1'b0;
          w_state_nx = ST_OFF;
        end
      end
      ST_DRAIN: begin
        if (w_cnt_zero) begin
          w_sel_nx   = r_sel_pend;
          w_cnt_nx   = CNT_RLD;
          w_state_nx = ST_SETTLE;
        end else begin
          w_cnt_nx   = w_cnt_dec;
        end
      end
      ST_SETTLE: begin
        if (w_mismatch) begin
          w_sel_nx   = r_sel_pend;
          w_cnt_nx   = CNT_RLD;
        end else if (w_cnt_zero) begin
          w_ena_nx   = w_s_ena;
          w_state_nx = w_s_ena ? ST_ON : ST_OFF;
        end else begin
          w_cnt_nx   = w_cnt_dec;
        end
      end
      default: begin
        w_state_nx = ST_OFF;
        w_ena_nx   = 1'b0;
      end
    endcase
  end

  // Busy covers an active sequence or one about to start.
  always_comb begin
    w_busy = w_mismatch;
    if ((r_state == ST_DRAIN) || (r_state == ST_SETTLE)) begin
      w_busy = 1'b1;
    end
  end

  assign spine_sel = r_spine_sel;
  assign spine_ena = r_spine_ena;
  assign sel_pend  = r_sel_pend;
  assign busy      = w_busy;

endmodule
